// File: rtl/sponge_pkg.sv
// Shared types and defaults for the Keccak sponge control unit.
package sponge_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        ABSORB  = 3'd2,
        PERMUTE = 3'd3,
        SQUEEZE = 3'd4
    } cu_state_t;

    typedef enum logic [1:0] {
        SEL_ROUND = 2'd0,
        SEL_LOAD  = 2'd1,
        SEL_HOLD  = 2'd2,
        SEL_XOR   = 2'd3
    } state_sel_t;

    localparam int DEFAULT_ROUNDS     = 24;
    localparam int DEFAULT_MAX_BLOCKS = 8;
    localparam int DEFAULT_SQ_W       = 8;

endpackage

// File: rtl/sponge_round_counter.sv
// Round index counter for one Keccak permutation: 0..ROUNDS-1, wraps after the last round.
module sponge_round_counter #(
    parameter int ROUNDS = 24,
    localparam int RW = $clog2(ROUNDS)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          enable,
    output logic [RW-1:0] round_idx,
    output logic          last_round
);

    logic [RW-1:0] count_reg;

    assign last_round = (count_reg == RW'(ROUNDS - 1));
    assign round_idx  = count_reg;

    // Wrapping to zero leaves the counter ready for the next permutation.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count_reg <= '0;
        end else if (enable) begin
            if (last_round) begin
                count_reg <= '0;
            end else begin
                count_reg <= count_reg + RW'(1);
            end
        end
    end

endmodule

// File: rtl/sponge_control_unit.sv
// Keccak sponge sequencer: buffer fill, absorb/permute, programmable squeeze.
// Optional SPONGE_ABORT_EN adds an abort input that drops any operation back to IDLE.
module sponge_control_unit
    import sponge_pkg::*;
#(
    parameter int MAX_BLOCKS = DEFAULT_MAX_BLOCKS,
    parameter int ROUNDS     = DEFAULT_ROUNDS,
    parameter int SQ_W       = DEFAULT_SQ_W,
    localparam int AW = $clog2(MAX_BLOCKS),
    localparam int RW = $clog2(ROUNDS)
) (
    input  logic            clock,
    input  logic            reset,
`ifdef SPONGE_ABORT_EN
    input  logic            abort,
`endif
    input  logic            start,
    input  logic [SQ_W-1:0] squeeze_blocks,
    input  logic            blk_valid,
    input  logic            blk_last,
    output logic            blk_ready,
    output logic [AW-1:0]   wr_addr,
    output logic [AW-1:0]   rd_addr,
    output logic [1:0]      state_sel,
    output logic [RW-1:0]   round_idx,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_last,
    output logic            busy,
    output logic            full,
    output logic            done
);

    cu_state_t       state_reg;
    state_sel_t      state_sel_reg;
    logic [SQ_W-1:0] sq_reg;
    logic [SQ_W-1:0] out_cnt_reg;
    logic [AW:0]     nblk_reg;
    logic [AW:0]     blk_idx_reg;
    logic [AW-1:0]   wr_addr_reg;
    logic [AW-1:0]   rd_addr_reg;
    logic            blk_ready_reg;
    logic            out_valid_reg;
    logic            out_last_reg;
    logic            busy_reg;
    logic            done_reg;
    logic            squeezing_reg;

    logic            abort_req;
    logic            wren;
    logic            buf_full_hit;
    logic            blk_final;
    logic [AW:0]     blk_idx_inc;
    logic            blocks_remain;
    logic [SQ_W-1:0] sq_eff;
    logic            last_round;
    logic            cnt_clear;

`ifdef SPONGE_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign wren          = blk_valid & blk_ready_reg;
    assign buf_full_hit  = (wr_addr_reg == AW'(MAX_BLOCKS - 1));
    // A block landing in the last buffer slot ends the fill even without blk_last.
    assign blk_final     = wren & (blk_last | buf_full_hit);
    assign full          = wren & buf_full_hit & ~blk_last;
    assign blk_idx_inc   = blk_idx_reg + (AW+1)'(1);
    assign blocks_remain = (blk_idx_inc < nblk_reg);
    assign sq_eff        = (squeeze_blocks == '0) ? SQ_W'(1) : squeeze_blocks;
    assign cnt_clear     = abort_req & (state_reg != IDLE);

    sponge_round_counter #(
        .ROUNDS (ROUNDS)
    ) u_round_counter (
        .clock      (clock),
        .reset      (reset),
        .clear      (cnt_clear),
        .enable     (state_reg == PERMUTE),
        .round_idx  (round_idx),
        .last_round (last_round)
    );

    always_ff @(posedge clock) begin
        if (reset || cnt_clear) begin
            state_reg     <= IDLE;
            state_sel_reg <= SEL_HOLD;
            sq_reg        <= SQ_W'(1);
            out_cnt_reg   <= '0;
            nblk_reg      <= '0;
            blk_idx_reg   <= '0;
            wr_addr_reg   <= '0;
            rd_addr_reg   <= '0;
            blk_ready_reg <= 1'b0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            squeezing_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        sq_reg        <= sq_eff;
                        out_cnt_reg   <= '0;
                        wr_addr_reg   <= '0;
                        blk_idx_reg   <= '0;
                        squeezing_reg <= 1'b0;
                        busy_reg      <= 1'b1;
                        blk_ready_reg <= 1'b1;
                        state_reg     <= LOAD;
                    end
                end
                LOAD: begin
                    if (blk_final) begin
                        nblk_reg      <= {1'b0, wr_addr_reg} + (AW+1)'(1);
                        blk_ready_reg <= 1'b0;
                        blk_idx_reg   <= '0;
                        rd_addr_reg   <= '0;
                        state_sel_reg <= SEL_LOAD;
                        state_reg     <= ABSORB;
                    end else if (wren) begin
                        wr_addr_reg <= wr_addr_reg + AW'(1);
                    end
                end
                ABSORB: begin
                    state_sel_reg <= SEL_ROUND;
                    state_reg     <= PERMUTE;
                end
                PERMUTE: begin
                    if (last_round) begin
                        if (!squeezing_reg && blocks_remain) begin
                            blk_idx_reg   <= blk_idx_inc;
                            rd_addr_reg   <= blk_idx_inc[AW-1:0];
                            state_sel_reg <= SEL_XOR;
                            state_reg     <= ABSORB;
                        end else begin
                            squeezing_reg <= 1'b1;
                            state_sel_reg <= SEL_HOLD;
                            out_valid_reg <= 1'b1;
                            out_last_reg  <= (out_cnt_reg == sq_reg - SQ_W'(1));
                            state_reg     <= SQUEEZE;
                        end
                    end
                end
                SQUEEZE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        out_last_reg  <= 1'b0;
                        if (out_last_reg) begin
                            done_reg  <= 1'b1;
                            busy_reg  <= 1'b0;
                            state_reg <= IDLE;
                        end else begin
                            out_cnt_reg   <= out_cnt_reg + SQ_W'(1);
                            state_sel_reg <= SEL_ROUND;
                            state_reg     <= PERMUTE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign blk_ready = blk_ready_reg;
    assign wr_addr   = wr_addr_reg;
    assign rd_addr   = rd_addr_reg;
    assign state_sel = state_sel_reg;
    assign out_valid = out_valid_reg;
    assign out_last  = out_last_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;

endmodule
